// File: rtl/inst_aligner.sv
// Halfword realignment buffer between the 32-bit fetch port and decode.
// Optional fetch address check enabled by defining ALIGNER_PC_CHECK_EN (adds pc_mismatch).
module inst_aligner #(
    parameter int unsigned BUF_HW   = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_data,
    input  logic [31:0] fetch_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        Inst_Compr
`ifdef ALIGNER_PC_CHECK_EN
    ,
    output logic        pc_mismatch
`endif
);

    localparam int unsigned CW = $clog2(BUF_HW + 1);

    logic [15:0]   buf_q [BUF_HW];
    logic [15:0]   buf_d [BUF_HW];
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_q, pc_d;
    logic          drop_q, drop_d;

    logic          is_compr_c;
    logic          accept_c;
    logic          issue_c;
    logic [CW-1:0] pop_c;
    logic [CW-1:0] push_c;
    logic [CW-1:0] base_c;
    logic [15:0]   first_hw_c;

    // Decode of the head halfword; outputs read registered state only
    assign is_compr_c  = (buf_q[0][1:0] != 2'b11);
    assign inst_valid  = ((count_q >= CW'(1)) && is_compr_c) ||
                         ((count_q >= CW'(2)) && !is_compr_c);
    assign fetch_ready = (count_q <= CW'(BUF_HW - 2));
    assign Inst_Compr  = (count_q != '0) && is_compr_c;
    assign inst_out    = (count_q == '0) ? 32'h0 :
                         is_compr_c      ? {16'h0, buf_q[0]} : {buf_q[1], buf_q[0]};
    assign inst_pc     = pc_q;

    assign accept_c   = fetch_valid && fetch_ready;
    assign issue_c    = inst_valid && inst_ready;
    assign pop_c      = issue_c ? (is_compr_c ? CW'(1) : CW'(2)) : '0;
    assign push_c     = accept_c ? (drop_q ? CW'(1) : CW'(2)) : '0;
    assign base_c     = count_q - pop_c;
    assign first_hw_c = drop_q ? fetch_data[31:16] : fetch_data[15:0];

    // Pop shifts survivors toward the head; pushes land right behind them
    always_comb begin
        buf_d   = buf_q;
        count_d = count_q;
        pc_d    = pc_q;
        drop_d  = drop_q;

        for (int unsigned i = 0; i < BUF_HW; i++) begin
            for (int unsigned j = 0; j < BUF_HW; j++) begin
                if (j == i + 32'(pop_c)) begin
                    buf_d[i] = buf_q[j];
                end
            end
            if ((push_c != '0) && (i == 32'(base_c))) begin
                buf_d[i] = first_hw_c;
            end
            if ((push_c == CW'(2)) && (i == 32'(base_c) + 32'd1)) begin
                buf_d[i] = fetch_data[31:16];
            end
        end

        count_d = count_q - pop_c + push_c;
        pc_d    = pc_q + (issue_c ? (is_compr_c ? 32'd2 : 32'd4) : 32'd0);
        if (accept_c) begin
            drop_d = 1'b0;
        end

        if (redirect) begin
            count_d = '0;
            pc_d    = redirect_pc;
            drop_d  = redirect_pc[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < BUF_HW; i++) begin
                buf_q[i] <= 16'h0;
            end
            count_q <= '0;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

`ifdef ALIGNER_PC_CHECK_EN
    logic [31:0] exp_fetch_q;
    logic        mismatch_q;

    // Expected fetch address follows the redirect target word and each accepted word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_fetch_q <= RESET_PC & ~32'h3;
            mismatch_q  <= 1'b0;
        end else if (redirect) begin
            exp_fetch_q <= redirect_pc & ~32'h3;
            mismatch_q  <= 1'b0;
        end else if (accept_c) begin
            exp_fetch_q <= exp_fetch_q + 32'd4;
            if (fetch_pc != exp_fetch_q) begin
                mismatch_q <= 1'b1;
            end
        end
    end

    assign pc_mismatch = mismatch_q;
`else
    logic unused_fetch_pc_c;
    assign unused_fetch_pc_c = ^fetch_pc;
`endif

endmodule

// File: tb/tb_inst_aligner.sv
// Directed bench for inst_aligner: halfword-queue reference model checked every cycle,
// plus literal expectations on the issued instruction stream.
module tb_inst_aligner;

    localparam int unsigned BUF_HW   = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [31:0] fetch_data = 32'h0;
    logic [31:0] fetch_pc = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        Inst_Compr;
`ifdef ALIGNER_PC_CHECK_EN
    logic        pc_mismatch;
`endif

    inst_aligner #(.BUF_HW(BUF_HW), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_data  (fetch_data),
        .fetch_pc    (fetch_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc),
        .Inst_Compr  (Inst_Compr)
`ifdef ALIGNER_PC_CHECK_EN
        ,
        .pc_mismatch (pc_mismatch)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of halfwords plus the running PC
    logic [15:0] hq[$];
    logic [31:0] mpc   = RESET_PC;
    logic        mdrop = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        c;
    } iss_t;
    iss_t act_log[$];

    function automatic logic head_compr();
        return (hq.size() > 0) && (hq[0][1:0] != 2'b11);
    endfunction

    function automatic logic head_valid();
        return ((hq.size() >= 1) && head_compr()) || ((hq.size() >= 2) && !head_compr());
    endfunction

    task automatic model_step();
        logic c, v, rdy;
        if (reset) begin
            hq.delete();
            mpc   = RESET_PC;
            mdrop = 1'b0;
        end else if (redirect) begin
            hq.delete();
            mpc   = redirect_pc;
            mdrop = redirect_pc[1];
        end else begin
            c   = head_compr();
            v   = head_valid();
            rdy = (hq.size() <= BUF_HW - 2);
            if (v && inst_ready) begin
                void'(hq.pop_front());
                if (!c) void'(hq.pop_front());
                mpc = mpc + (c ? 32'd2 : 32'd4);
            end
            if (fetch_valid && rdy) begin
                if (!mdrop) hq.push_back(fetch_data[15:0]);
                hq.push_back(fetch_data[31:16]);
                mdrop = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    // Per-cycle comparison against the model, and capture of issued instructions
    initial forever begin
        logic ev;
        @(negedge clk);
        ev = head_valid();
        check("inst_valid", 32'(inst_valid), 32'(ev));
        check("fetch_ready", 32'(fetch_ready), 32'(hq.size() <= BUF_HW - 2));
        check("inst_pc", inst_pc, mpc);
        if (ev) begin
            check("Inst_Compr", 32'(Inst_Compr), 32'(head_compr()));
            check("inst_out", inst_out, head_compr() ? {16'h0, hq[0]} : {hq[1], hq[0]});
        end
        if (reset) begin
            check("inst_out_rst", inst_out, 32'h0);
            check("Inst_Compr_rst", 32'(Inst_Compr), 32'h0);
        end
        if (inst_valid && inst_ready && !redirect && !reset) begin
            act_log.push_back('{pc: inst_pc, inst: inst_out, c: Inst_Compr});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        tick(1);
        redirect = 1'b0;
        act_log.delete();
    endtask

    task automatic send_word(input logic [31:0] d, input logic [31:0] pc);
        logic ok;
        ok          = 1'b0;
        fetch_valid = 1'b1;
        fetch_data  = d;
        fetch_pc    = pc;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (fetch_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        fetch_valid = 1'b0;
        check("send_accept", 32'(ok), 32'h1);
    endtask

    task automatic expect_iss(input int idx, input logic [31:0] pc, input logic [31:0] inst,
                              input logic c);
        if (idx < act_log.size()) begin
            check($sformatf("iss%0d_pc", idx), act_log[idx].pc, pc);
            check($sformatf("iss%0d_inst", idx), act_log[idx].inst, inst);
            check($sformatf("iss%0d_compr", idx), 32'(act_log[idx].c), 32'(c));
        end
    endtask

    initial begin
        reset = 1'b1;
        tick(2);
        check("rst_inst_valid", 32'(inst_valid), 32'h0);
        check("rst_inst_out", inst_out, 32'h0);
        check("rst_compr", 32'(Inst_Compr), 32'h0);
        check("rst_fetch_ready", 32'(fetch_ready), 32'h1);
        check("rst_inst_pc", inst_pc, RESET_PC);
        reset = 1'b0;
        tick(1);

        // Two full-width instructions
        inst_ready = 1'b1;
        act_log.delete();
        send_word(32'h0000_0013, 32'h0);
        send_word(32'h0000_0093, 32'h4);
        tick(4);
        check("t1_count", act_log.size(), 2);
        expect_iss(0, 32'h0, 32'h0000_0013, 1'b0);
        expect_iss(1, 32'h4, 32'h0000_0093, 1'b0);

        // Two compressed instructions in one word
        do_redirect(32'h0);
        send_word(32'h4505_4501, 32'h0);
        tick(4);
        check("t2_count", act_log.size(), 2);
        expect_iss(0, 32'h0, 32'h0000_4501, 1'b1);
        expect_iss(1, 32'h2, 32'h0000_4505, 1'b1);

        // Straddling 32-bit instruction waits for the next word
        do_redirect(32'h0);
        send_word(32'h0013_4501, 32'h0);
        tick(3);
        check("t3_wait_valid", 32'(inst_valid), 32'h0);
        check("t3_wait_pc", inst_pc, 32'h2);
        send_word(32'hFFFF_0000, 32'h4);
        tick(3);
        check("t3_tail_valid", 32'(inst_valid), 32'h0);
        check("t3_tail_pc", inst_pc, 32'h6);
        check("t3_count", act_log.size(), 2);
        expect_iss(0, 32'h0, 32'h0000_4501, 1'b1);
        expect_iss(1, 32'h2, 32'h0000_0013, 1'b0);

        // Redirect to a halfword target drops the low half of the first word
        do_redirect(32'h0000_0102);
        send_word(32'h0513_ABCD, 32'h100);
        tick(2);
        check("t4_wait_valid", 32'(inst_valid), 32'h0);
        check("t4_wait_pc", inst_pc, 32'h102);
        send_word(32'h4501_0000, 32'h104);
        tick(4);
        check("t4_count", act_log.size(), 2);
        expect_iss(0, 32'h102, 32'h0000_0513, 1'b0);
        expect_iss(1, 32'h106, 32'h0000_4501, 1'b1);

`ifdef ALIGNER_PC_CHECK_EN
        check("pcchk_clean", 32'(pc_mismatch), 32'h0);
        send_word(32'h0000_0013, 32'h200);
        tick(1);
        check("pcchk_set", 32'(pc_mismatch), 32'h1);
        do_redirect(32'h0);
        check("pcchk_clr", 32'(pc_mismatch), 32'h0);
`endif

        // Backpressure: buffer fills, fetch_ready drops, nothing lost
        inst_ready = 1'b0;
        do_redirect(32'h0);
        send_word(32'h0000_0013, 32'h0);
        send_word(32'h4505_4501, 32'h4);
        fetch_valid = 1'b1;
        fetch_data  = 32'h0000_0093;
        fetch_pc    = 32'h8;
        tick(3);
        check("t5_full_ready", 32'(fetch_ready), 32'h0);
        check("t5_hold_valid", 32'(inst_valid), 32'h1);
        check("t5_hold_out", inst_out, 32'h0000_0013);
        inst_ready = 1'b1;
        send_word(32'h0000_0093, 32'h8);
        tick(6);
        check("t5_count", act_log.size(), 4);
        expect_iss(0, 32'h0, 32'h0000_0013, 1'b0);
        expect_iss(1, 32'h4, 32'h0000_4501, 1'b1);
        expect_iss(2, 32'h6, 32'h0000_4505, 1'b1);
        expect_iss(3, 32'h8, 32'h0000_0093, 1'b0);

        // Reset mid-stream with three halfwords buffered
        inst_ready = 1'b0;
        do_redirect(32'h2);
        send_word(32'h4501_0000, 32'h0);
        send_word(32'h0013_0001, 32'h4);
        tick(1);
        check("t6_pre_valid", 32'(inst_valid), 32'h1);
        check("t6_pre_pc", inst_pc, 32'h2);
        reset      = 1'b1;
        inst_ready = 1'b1;
        #1;
        check("t6_rst_valid", 32'(inst_valid), 32'h0);
        check("t6_rst_out", inst_out, 32'h0);
        check("t6_rst_compr", 32'(Inst_Compr), 32'h0);
        check("t6_rst_pc", inst_pc, RESET_PC);
        tick(2);
        reset = 1'b0;
        tick(1);
        check("t6_post_ready", 32'(fetch_ready), 32'h1);
        check("t6_post_valid", 32'(inst_valid), 32'h0);
        tick(2);
        check("t6_no_issue", act_log.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_aligner.md
Name: inst_aligner

Overview:
- Instruction realignment buffer in the IF stage, between the 32-bit fetch memory port and decode.
- Accepts word-aligned 32-bit fetch words and emits one instruction per handshake.
- Per instruction, outputs its PC and the Inst_Compr flag consumed by the PC adder (+2 compressed / +4 full).
- Handles 32-bit instructions that straddle fetch words, and redirects to halfword-aligned targets.

Parameters:
- BUF_HW, 4, depth of the halfword buffer (minimum 4; holds one leftover halfword plus one incoming word plus margin).
- RESET_PC, 32'h0000_0000, value of inst_pc after reset.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous active-high reset
- fetch_valid  input  1  fetch_data/fetch_pc valid
- fetch_ready  output  1  buffer can accept a word this cycle
- fetch_data  input  32  fetched word, little-endian halfwords
- fetch_pc  input  32  word address of fetch_data, bits[1:0]=0
- redirect  input  1  branch/jump/trap redirect: flush buffer
- redirect_pc  input  32  new PC, bit[0]=0, bit[1] may be 1
- inst_valid  output  1  inst_out holds a complete instruction
- inst_ready  input  1  decode accepts the instruction
- inst_out  output  32  instruction; compressed instructions zero-extended in [15:0]
- inst_pc  output  32  PC of inst_out
- Inst_Compr  output  1  1 = 16-bit RVC instruction, 0 = 32-bit

Behaviour:
- Reset (async): buffer empty (count=0), inst_pc=RESET_PC, drop_low=0.
  - Outputs during reset: inst_valid=0, inst_out=0, Inst_Compr=0, fetch_ready=1.
- Buffer: FIFO of halfwords with count 0..BUF_HW; head = oldest halfword.
- fetch_ready = (count <= BUF_HW-2). The registered count is used, so there is no combinational path from inst_ready.
- Fetch accept (fetch_valid & fetch_ready):
  - Pushes fetch_data[15:0] then [31:16].
  - If drop_low=1, pushes only [31:16] and clears drop_low.
- Decode rule on head:
  - Inst_Compr = (head[1:0] != 2'b11).
  - inst_valid = (count>=1 & Inst_Compr) | (count>=2 & !Inst_Compr).
  - inst_out = {16'h0, head} if compressed; otherwise {head+1, head}.
  - Outputs are combinational from registered state.
- Issue (inst_valid & inst_ready):
  - Pops 1 halfword if compressed, else 2.
  - inst_pc <= inst_pc + (Inst_Compr ? 2 : 4).
- Simultaneous push and pop in one cycle: count_next = count + pushed − popped; ordering preserved.
- Straddle: 32-bit instruction at PC[1]=1 waits with inst_valid=0 until the next word arrives. No partial instruction is ever presented.
- Redirect (highest priority, synchronous):
  - Empties buffer; inst_pc <= redirect_pc; drop_low <= redirect_pc[1].
  - Any fetch or issue handshake in the same cycle is discarded.
  - inst_valid=0 in the following cycle.
- fetch_pc is used only for the optional check; inst_pc is tracked internally.
- Valid/data stability: once inst_valid=1, inst_out, inst_pc and Inst_Compr stay stable until issue or redirect.
- Wrap: inst_pc wraps modulo 2^32 (32'hFFFF_FFFE + 2 = 0).
- Reset asserted mid-operation: immediate clear as at power-up; no instruction issued during reset.

Optional Feature:
- Macro ALIGNER_PC_CHECK_EN.
- Defined:
  - On every fetch accept, compare fetch_pc with the expected next fetch address. The expected address is tracked from redirect_pc & ~3 and increments by 4 per accepted word.
  - A mismatch sets sticky output pc_mismatch (1 bit, reset 0, cleared by redirect).
  - The mismatching word is still buffered.
- Undefined: port pc_mismatch absent; no comparison logic.

Test Plan:
- Reset, then words 32'h0000_0013, 32'h0000_0093 (32-bit ops) with inst_ready=1 -> two issues: inst_pc 0 then 4, Inst_Compr=0, inst_out 32'h13 then 32'h93.
- Word 32'h4505_4501 (two c.li) -> issues 16'h4501 @pc0 then 16'h4505 @pc2, both Inst_Compr=1, inst_out upper 16 bits = 0.
- Words 32'h0013_4501, 32'hxxxx_0000 -> c.li @0, then 32-bit 32'h0000_0013 @2 issued only after the second word; inst_valid=0 between.
- redirect with redirect_pc=32'h0000_0102, then word 32'h0513_ABCD @0x100 -> low half dropped. Head 16'h0513 (32-bit) waits for the next word; inst_pc=0x102.
- inst_ready=0 while 3 words are offered -> fetch_ready drops at count>BUF_HW-2. No word is lost; the full sequence is issued in order once inst_ready=1.
- Assert reset mid-stream with count=3 -> inst_valid=0 immediately, inst_pc=RESET_PC, fetch_ready=1 after release.
